// File: rtl/uart_word_tx_if.sv
// Valid/ready beat carrying one result vector into the UART word transmitter.
interface uart_word_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/uart_word_tx.sv
// Serializes a NUM_WORDS-word result vector onto the UART tx line,
// LSB word first, LSB bit first, one frame per word with no inter-frame gap.
module uart_word_tx #(
    parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
    parameter int BITS_PER_WORD    = 8,
    parameter int PACKET_SIZE      = BITS_PER_WORD + 5,
    parameter int NUM_WORDS        = 2
) (
    input  logic           clk,
    input  logic           rstn,
    uart_word_tx_if.slave  s,
    output logic           tx,
    output logic           busy
);
    localparam int DW        = NUM_WORDS * BITS_PER_WORD;
    localparam int STOP_BITS = PACKET_SIZE - BITS_PER_WORD - 1;
    localparam int PW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BW = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [PW-1:0] PULSE_MAX = PW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_MAX   = BW'(PACKET_SIZE - 1);
    localparam logic [WW-1:0] WORD_MAX  = WW'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PW-1:0]          pulse_q;
    logic [BW-1:0]          bit_q;
    logic [WW-1:0]          word_q;
    logic [PACKET_SIZE-1:0] shift_q;
    logic [DW-1:0]          buf_q;

    logic pulse_end;
    logic bit_end;
    logic word_end;
    logic last;
    logic accept;

    assign pulse_end = (pulse_q == PULSE_MAX);
    assign bit_end   = (bit_q == BIT_MAX);
    assign word_end  = (word_q == WORD_MAX);
    assign last      = pulse_end && bit_end && word_end;
    assign accept    = (state_q == IDLE) && s.s_valid;

    // The shift register idles at all ones, so tx is high whenever nothing is sent.
    assign tx = shift_q[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (s.s_valid) state_d = SEND;
            SEND: if (last)      state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_comb begin
        s.s_ready = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: s.s_ready = 1'b1;
            SEND: busy      = 1'b1;
            default: begin
                s.s_ready = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // buf_q holds the words not yet framed; word 0 goes straight to the shifter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pulse_q <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            shift_q <= '1;
            buf_q   <= '0;
        end else if (accept) begin
            pulse_q <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            shift_q <= {{STOP_BITS{1'b1}}, s.s_data[BITS_PER_WORD-1:0], 1'b0};
            buf_q   <= s.s_data >> BITS_PER_WORD;
        end else if (state_q == SEND) begin
            if (pulse_end) begin
                pulse_q <= '0;
                if (bit_end) begin
                    bit_q <= '0;
                    if (word_end) begin
                        word_q  <= '0;
                        shift_q <= '1;
                    end else begin
                        word_q  <= word_q + 1'b1;
                        shift_q <= {{STOP_BITS{1'b1}},
                                    buf_q[BITS_PER_WORD-1:0], 1'b0};
                        buf_q   <= buf_q >> BITS_PER_WORD;
                    end
                end else begin
                    bit_q   <= bit_q + 1'b1;
                    shift_q <= {1'b1, shift_q[PACKET_SIZE-1:1]};
                end
            end else begin
                pulse_q <= pulse_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: two-word and one-word instances,
// four clocks per bit, every tx cycle compared against the expected frame.
module tb_uart_word_tx;
    logic clk;
    logic rstn;
    logic tx;
    logic busy;
    logic tx1;
    logic busy1;

    int n_checks = 0;
    int n_fail   = 0;

    uart_word_tx_if #(.DATA_WIDTH(16)) bus ();
    uart_word_tx_if #(.DATA_WIDTH(8))  bus1 ();

    uart_word_tx #(
        .CLOCKS_PER_PULSE(4),
        .BITS_PER_WORD(8),
        .PACKET_SIZE(13),
        .NUM_WORDS(2)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .s(bus.slave),
        .tx(tx),
        .busy(busy)
    );

    uart_word_tx #(
        .CLOCKS_PER_PULSE(4),
        .BITS_PER_WORD(8),
        .PACKET_SIZE(13),
        .NUM_WORDS(1)
    ) dut1 (
        .clk(clk),
        .rstn(rstn),
        .s(bus1.slave),
        .tx(tx1),
        .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered 1 time unit after the handshake edge; walks every cycle of the beat.
    task automatic check_beat(input logic [15:0] d, input int nw,
                              input bit scramble, input string tag);
        logic [12:0] fr;
        logic t;
        logic bz;
        logic rd;
        for (int w = 0; w < nw; w++) begin
            fr = {4'hF, d[w*8 +: 8], 1'b0};
            for (int b = 0; b < 13; b++) begin
                for (int c = 0; c < 4; c++) begin
                    t  = (nw == 1) ? tx1 : tx;
                    bz = (nw == 1) ? busy1 : busy;
                    rd = (nw == 1) ? bus1.s_ready : bus.s_ready;
                    check($sformatf("%s w%0d b%0d c%0d tx", tag, w, b, c),
                          {31'd0, t}, {31'd0, fr[b]});
                    check($sformatf("%s w%0d b%0d c%0d busy", tag, w, b, c),
                          {31'd0, bz}, 32'd1);
                    if (c == 0)
                        check($sformatf("%s w%0d b%0d ready", tag, w, b),
                              {31'd0, rd}, 32'd0);
                    if (scramble) bus.s_data = 16'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
        end
        t  = (nw == 1) ? tx1 : tx;
        bz = (nw == 1) ? busy1 : busy;
        rd = (nw == 1) ? bus1.s_ready : bus.s_ready;
        check({tag, " end busy"}, {31'd0, bz}, 32'd0);
        check({tag, " end ready"}, {31'd0, rd}, 32'd1);
        check({tag, " end tx"}, {31'd0, t}, 32'd1);
    endtask

    task automatic start_beat(input logic [15:0] d, input string tag);
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        check({tag, " ready before"}, {31'd0, bus.s_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    initial begin
        rstn         = 1'b0;
        bus.s_data   = 16'hA53C;
        bus.s_valid  = 1'b1;
        bus1.s_data  = 8'h00;
        bus1.s_valid = 1'b0;

        // Reset held with valid asserted: nothing may start.
        repeat (3) @(posedge clk);
        #1;
        check("rst tx", {31'd0, tx}, 32'd1);
        check("rst ready", {31'd0, bus.s_ready}, 32'd1);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst tx1", {31'd0, tx1}, 32'd1);
        check("rst busy1", {31'd0, busy1}, 32'd0);

        rstn = 1'b1;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        check("acc ready", {31'd0, bus.s_ready}, 32'd0);
        check_beat(16'hA53C, 2, 1'b0, "basic");

        // Held valid with data churning during the beat.
        repeat (2) @(posedge clk);
        #1;
        start_beat(16'h1234, "held");
        bus.s_valid = 1'b1;
        check_beat(16'h1234, 2, 1'b1, "held");
        bus.s_data = 16'h5AC3;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        check_beat(16'h5AC3, 2, 1'b0, "held2");

        // Reset during bit 5 of word 0 (a zero bit of 0xE3).
        repeat (2) @(posedge clk);
        #1;
        start_beat(16'h00E3, "midrst");
        repeat (22) @(posedge clk);
        #1;
        check("midrst pre tx", {31'd0, tx}, 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst tx", {31'd0, tx}, 32'd1);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst ready", {31'd0, bus.s_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("midrst held tx", {31'd0, tx}, 32'd1);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("midrst idle tx", {31'd0, tx}, 32'd1);
        check("midrst idle busy", {31'd0, busy}, 32'd0);
        start_beat(16'h00FF, "after_rst");
        check_beat(16'h00FF, 2, 1'b0, "after_rst");

        start_beat(16'h0000, "zeros");
        check_beat(16'h0000, 2, 1'b0, "zeros");
        start_beat(16'hFFFF, "ones");
        check_beat(16'hFFFF, 2, 1'b0, "ones");

        // Single-word instance.
        bus1.s_data  = 8'h81;
        bus1.s_valid = 1'b1;
        check("nw1 ready before", {31'd0, bus1.s_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus1.s_valid = 1'b0;
        check_beat(16'h0081, 1, 1'b0, "nw1");
        check("nw1 other idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
